// File: rtl/pipe_pkg.sv
// Shared widths, bus layouts, op codes and FSM states for the x -> y -> z pipeline.
package pipe_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;

  localparam int unsigned X2Y_W = TAG_W + 2 + 2 * XLEN;
  localparam int unsigned Y2Z_W = TAG_W + XLEN;

  // x -> y bus: {tag, op, src1, src2}
  localparam int unsigned X2Y_SRC2_LSB = 0;
  localparam int unsigned X2Y_SRC1_LSB = XLEN;
  localparam int unsigned X2Y_OP_LSB   = 2 * XLEN;
  localparam int unsigned X2Y_TAG_LSB  = 2 * XLEN + 2;

  // y -> z bus: {tag, result}
  localparam int unsigned Y2Z_RES_LSB = 0;
  localparam int unsigned Y2Z_TAG_LSB = XLEN;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} y_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
  } x2y_pkt_t;

endpackage

// File: rtl/stage_y_if.sv
// Handshake and data signals around stage y: x -> y input side, y -> z output side, flush.
interface stage_y_if;
  import pipe_pkg::*;

  logic             x_to_y_valid;
  logic [X2Y_W-1:0] x_to_y_bus;
  logic             y_allow_in;
  logic             y_to_z_valid;
  logic [Y2Z_W-1:0] y_to_z_bus;
  logic             z_allow_in;
  logic             flush;

  // Stage y's view.
  modport slave (
    input  x_to_y_valid, x_to_y_bus, z_allow_in, flush,
    output y_allow_in, y_to_z_valid, y_to_z_bus
  );

  // Environment's view (stage x / stage z / flush source).
  modport master (
    output x_to_y_valid, x_to_y_bus, z_allow_in, flush,
    input  y_allow_in, y_to_z_valid, y_to_z_bus
  );

endinterface

// File: rtl/iter_mul64.sv
// Shift-and-add multiplier: one multiplier bit per cycle, XLEN cycles per product.
module iter_mul64
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_sum;

  // Accumulate the current partial product; the last step's sum is the final product.
  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (kill) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = src1;
      mplier_d = src2;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LastCnt) busy_d = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LastCnt);
  assign product = acc_sum;

endmodule

// File: rtl/stage_y.sv
// Pipeline stage y: PASS/ADD in one cycle, iterative MUL, valid/allow-in handshake to x and z.
module stage_y
  import pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  stage_y_if.slave  yif
);

  y_state_e         state_q, state_d;
  logic             y_valid_q, y_valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;

  x2y_pkt_t         pkt;
  logic             y_ready_go;
  logic             y_allow_in;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [XLEN-1:0]  mul_product;

  assign pkt        = yif.x_to_y_bus;
  assign y_ready_go = (state_q != BUSY);
  assign y_allow_in = !y_valid_q || (y_ready_go && yif.z_allow_in);
  assign accept     = yif.x_to_y_valid && y_allow_in && !yif.flush;

  iter_mul64 u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .src1    (pkt.src1),
    .src2    (pkt.src2),
    .kill    (yif.flush),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state: flush wins, then accept of a new packet, then FSM progress.
  always_comb begin
    state_d   = state_q;
    y_valid_d = y_valid_q;
    tag_d     = tag_q;
    result_d  = result_q;
    mul_start = 1'b0;
    if (yif.flush) begin
      y_valid_d = 1'b0;
      state_d   = IDLE;
    end else begin
      if (y_allow_in) y_valid_d = yif.x_to_y_valid;
      if (accept) begin
        tag_d = pkt.tag;
        case (pkt.op)
          OP_MUL: begin
            state_d   = BUSY;
            mul_start = 1'b1;
          end
          OP_ADD: begin
            state_d  = DONE;
            result_d = pkt.src1 + pkt.src2;
          end
          default: begin
            // Reserved op code behaves as PASS.
            state_d  = DONE;
            result_d = pkt.src1;
          end
        endcase
      end else begin
        unique case (state_q)
          BUSY: begin
            if (mul_done) begin
              state_d  = DONE;
              result_d = mul_product;
            end
          end
          DONE: begin
            if (yif.z_allow_in) state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      y_valid_q <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= y_valid_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
    end
  end

  assign yif.y_allow_in   = y_allow_in;
  assign yif.y_to_z_valid = y_valid_q && y_ready_go;
  assign yif.y_to_z_bus   = {tag_q, result_q};

  // The multiplier runs exactly while the stage sits in BUSY.
  always_ff @(posedge clk) begin
    if (reset) assert (mul_busy == (state_q == BUSY));
  end

endmodule

// File: tb/tb_stage_y.sv
// Self-checking bench for stage_y with a result scoreboard.
module tb_stage_y;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stage_y_if yif ();

  stage_y dut (
    .clk   (clk),
    .reset (reset),
    .yif   (yif)
  );

  int checks = 0;
  int failures = 0;
  logic [Y2Z_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      2'd1:    r = a + b;
      2'd2:    r = a * b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Scoreboard: every transfer to z must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && yif.y_to_z_valid && yif.z_allow_in) begin
      if (exp_q.size() == 0) check("unexpected_output", yif.y_to_z_bus, '0);
      else check("result", yif.y_to_z_bus, exp_q.pop_front());
    end
  end

  // Present a packet until accepted; call just after a rising edge, returns just after one.
  task automatic send(input logic [TAG_W-1:0] tag, input logic [1:0] op,
                      input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2, input bit push);
    bit ok;
    ok = 1'b0;
    yif.x_to_y_bus   = {tag, op, s1, s2};
    yif.x_to_y_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (yif.y_allow_in && !yif.flush) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    else if (push) exp_q.push_back({tag, model(op, s1, s2)});
    @(posedge clk);
    #1;
    yif.x_to_y_valid = 1'b0;
  endtask

  // Count negedges until y_to_z_valid, and how many of them had y_allow_in low.
  task automatic wait_out(output int lat, output int lows);
    lat = 0;
    lows = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (yif.y_to_z_valid) begin
        lat = i;
        break;
      end
      if (!yif.y_allow_in) lows++;
    end
  endtask

  int lat, lows;
  logic [XLEN-1:0] r1, r2;
  logic [1:0] rop;

  initial begin
    yif.x_to_y_valid = 1'b0;
    yif.x_to_y_bus   = '0;
    yif.z_allow_in   = 1'b1;
    yif.flush        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", yif.y_to_z_valid, 0);
    check("rst_allow", yif.y_allow_in, 1);
    check("rst_bus", yif.y_to_z_bus, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ADD 3+4, tag 5
    send(5'd5, OP_ADD, 64'd3, 64'd4, 1'b1);
    @(negedge clk);
    check("add_valid", yif.y_to_z_valid, 1);
    check("add_bus", yif.y_to_z_bus, {5'd5, 64'd7});
    check("add_allow", yif.y_allow_in, 1);
    @(posedge clk);
    #1;

    // MUL all-ones * 2, tag 2
    send(5'd2, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    wait_out(lat, lows);
    check("mul_latency", lat, 65);
    check("mul_allow_low", lows, 64);
    check("mul_bus", yif.y_to_z_bus, {5'd2, 64'hFFFF_FFFF_FFFF_FFFE});
    @(posedge clk);
    #1;

    // ADD 0x10+0x20 then 5 stall cycles with a waiting packet
    send(5'd9, OP_ADD, 64'h10, 64'h20, 1'b1);
    yif.z_allow_in   = 1'b0;
    yif.x_to_y_bus   = {5'd10, OP_PASS, 64'hABC, 64'd0};
    yif.x_to_y_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", yif.y_to_z_valid, 1);
      check("stall_bus", yif.y_to_z_bus, {5'd9, 64'h30});
      check("stall_allow", yif.y_allow_in, 0);
    end
    @(posedge clk);
    #1;
    yif.z_allow_in = 1'b1;
    @(negedge clk);
    check("unstall_allow", yif.y_allow_in, 1);
    exp_q.push_back({5'd10, 64'hABC});
    @(posedge clk);
    #1;
    yif.x_to_y_valid = 1'b0;
    @(negedge clk);
    check("unstall_next", yif.y_to_z_bus, {5'd10, 64'hABC});
    @(posedge clk);
    #1;

    // Flush in IDLE drops a simultaneous packet
    yif.x_to_y_bus   = {5'd6, OP_PASS, 64'h66, 64'd0};
    yif.x_to_y_valid = 1'b1;
    yif.flush        = 1'b1;
    @(posedge clk);
    #1;
    yif.x_to_y_valid = 1'b0;
    yif.flush        = 1'b0;
    @(negedge clk);
    check("flush_drop", yif.y_to_z_valid, 0);
    @(posedge clk);
    #1;

    // MUL 7*9 flushed 20 cycles after accept, then ADD 1+1
    send(5'd3, OP_MUL, 64'd7, 64'd9, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    yif.flush = 1'b1;
    @(posedge clk);
    #1;
    yif.flush = 1'b0;
    @(negedge clk);
    check("flush_allow", yif.y_allow_in, 1);
    check("flush_valid", yif.y_to_z_valid, 0);
    @(posedge clk);
    #1;
    send(5'd4, OP_ADD, 64'd1, 64'd1, 1'b1);
    @(negedge clk);
    check("post_flush_bus", yif.y_to_z_bus, {5'd4, 64'd2});
    repeat (70) @(negedge clk);
    @(posedge clk);
    #1;

    // Eight back-to-back PASS packets
    for (int i = 0; i < 8; i++) begin
      yif.x_to_y_bus   = {5'(i), OP_PASS, 64'(100 + i), 64'd0};
      yif.x_to_y_valid = 1'b1;
      @(negedge clk);
      check("b2b_allow", yif.y_allow_in, 1);
      exp_q.push_back({5'(i), 64'(100 + i)});
      if (i > 0) check("b2b_valid", yif.y_to_z_valid, 1);
      @(posedge clk);
      #1;
    end
    yif.x_to_y_valid = 1'b0;
    @(negedge clk);
    check("b2b_last", yif.y_to_z_bus, {5'd7, 64'd107});
    @(posedge clk);
    #1;

    // Random ops, including wide MUL operands
    send(5'd11, OP_MUL, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rop = 2'($urandom_range(0, 3));
      r1  = {$urandom, $urandom};
      r2  = {$urandom, $urandom};
      send(5'(12 + k), rop, r1, r2, 1'b1);
    end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("rand_drain", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset 30 cycles into a MUL
    send(5'd1, OP_MUL, 64'd123, 64'd456, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", yif.y_to_z_valid, 0);
    check("midrst_allow", yif.y_allow_in, 1);
    check("midrst_bus", yif.y_to_z_bus, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(5'd7, OP_MUL, 64'd3, 64'd5, 1'b1);
    wait_out(lat, lows);
    check("mul2_latency", lat, 65);
    check("mul2_bus", yif.y_to_z_bus, {5'd7, 64'd15});

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_y.md
# stage_y

Pipeline stage y sits directly upstream of stage z. It accepts operand packets from stage x over the x→y valid/allow-in handshake and computes a 64-bit result. Single-cycle ops are PASS and ADD. MUL is iterative and takes 64 cycles. The stage presents `{tag, result}` to stage z on `y_to_z_bus`/`y_to_z_valid` and honours z's back-pressure via `z_allow_in`.

## Interface
- `XLEN`, 64: operand and result width.
- `TAG_W`, 5: destination tag width.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `x_to_y_valid` input 1: upstream packet valid.
- `x_to_y_bus` input TAG_W+2+2*XLEN: `{tag, op[1:0], src1, src2}`, MSB first.
- `y_allow_in` output 1: stage y can take a packet this cycle.
- `y_to_z_valid` output 1: result packet valid toward z.
- `y_to_z_bus` output TAG_W+XLEN: `{tag, result}`.
- `z_allow_in` input 1: z accepts this cycle.
- `flush` input 1: discard the packet held in y at the next edge.

## Operation
- Op encoding: 0 = PASS (result = src1); 1 = ADD (src1+src2 mod 2^64); 2 = MUL (low 64 bits of src1*src2, unsigned and signed identical); 3 = reserved, treated as PASS.
- Handshake:
  - `y_ready_go` = state != BUSY.
  - `y_allow_in` = !y_valid || (y_ready_go && z_allow_in).
  - `y_to_z_valid` = y_valid && y_ready_go.
- Accept: a packet is taken when `x_to_y_valid && y_allow_in && !flush`.
  - `y_valid` takes `x_to_y_valid && !flush` whenever `y_allow_in` is high.
  - The tag is captured on accept.
- PASS/ADD: the result is registered at accept and the state goes to DONE.
- MUL: on accept the state goes to BUSY with cnt=0, acc=0, mcand=src1, mplier=src2. Each BUSY cycle:
  - acc += mplier[0] ? mcand : 0;
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the cycle with cnt==63 the state goes to DONE and result = acc.
  - All arithmetic is truncated to XLEN.
- FSM states and transitions:
  - IDLE → DONE on PASS/ADD accept.
  - IDLE → BUSY on MUL accept.
  - BUSY → DONE after 64 cycles.
  - DONE → IDLE when `z_allow_in` is high and no new accept.
  - DONE → DONE/BUSY on a back-to-back accept.
- Flush: the next edge forces `y_valid`=0, state=IDLE and cnt=0. An in-flight MUL is aborted. A simultaneous `x_to_y_valid` is dropped, and x must not consider it consumed. Outputs in the flush cycle itself are not gated.
- Reset (async, any time, including mid-MUL):
  - `y_valid`=0, state=IDLE, cnt=0, acc/result/tag=0.
  - Outputs read `y_to_z_valid`=0, `y_allow_in`=1, `y_to_z_bus`=0.

## Timing
- PASS/ADD latency is 1: accepted at edge N, `y_to_z_valid` is high after edge N.
- MUL latency is 65: accepted at edge N, BUSY during cycles N+1..N+64, `y_to_z_valid` is high after edge N+64.
- `y_allow_in` is low throughout BUSY. During DONE it follows `z_allow_in`.
- Back-to-back PASS/ADD with `z_allow_in`=1 sustain 1 packet/cycle.
- Stall stability: while `y_to_z_valid && !z_allow_in`, `y_to_z_bus` and `y_to_z_valid` hold constant.
- `y_allow_in` depends combinationally on `z_allow_in`; this is the only combinational input→output path.

## Structure
- Package `pipe_pkg` holds:
  - XLEN and TAG_W;
  - bus width localparams `X2Y_W` and `Y2Z_W`;
  - field offsets;
  - op encodings `OP_PASS`, `OP_ADD`, `OP_MUL`;
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module `iter_mul64` takes start, src1, src2 and kill, and produces busy, done and product. It owns cnt, acc, mcand and mplier.
- `stage_y` owns the handshake, `y_valid`, tag, result register and the FSM.

## Test plan
- ADD, tag=5, src1=3, src2=4, z_allow_in=1 → next cycle `y_to_z_valid`=1, bus=`{5, 64'd7}`; `y_allow_in` stays 1.
- MUL, tag=2, src1=64'hFFFF_FFFF_FFFF_FFFF, src2=2 → `y_allow_in`=0 for 64 cycles; `y_to_z_valid` rises 65 cycles after accept with result 64'hFFFF_FFFF_FFFF_FFFE.
- ADD 0x10+0x20 then z_allow_in=0 for 5 cycles → bus holds `{tag, 64'h30}`, `y_allow_in`=0; a new packet is accepted the cycle z_allow_in returns.
- MUL 7*9 with flush asserted 20 cycles after accept → `y_to_z_valid` never rises for that packet; `y_allow_in`=1 the next cycle; a following ADD 1+1 completes normally with result 2.
- Eight back-to-back PASS packets, tags 0..7, z_allow_in=1 → eight consecutive valid cycles, tags in order, no bubbles.
- reset driven low 30 cycles into a MUL → immediate `y_to_z_valid`=0, `y_allow_in`=1, bus=0; after release, MUL 3*5 yields 15 at 65 cycles.
